// File: rtl/pe2ddr_writeback_pkg.sv
// Shared widths, writeback state encoding and the result quantizer.
// Latency: n/a (declarations and combinational functions only).
// Backpressure: n/a.
package pe2ddr_writeback_pkg;

  // Global datapath parameters
  localparam int DATA_W     = 16;
  localparam int RES_W      = 32;
  localparam int BATCH      = 4;
  localparam int DDR_BEAT_W = 4 * BATCH * DATA_W;
  localparam int DDR_ADDR_W = 32;
  localparam int BURST_W    = 8;

  // Bits needed to index n items (at least one bit)
  function automatic int bw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Writeback sequencing and command field widths
  typedef enum logic [2:0] {
    WB_IDLE,
    WB_ADDR,
    WB_DATA,
    WB_FLUSH,
    WB_DONE
  } wb_state_e;

  localparam int CMD_SHIFT_W = 5;

  // Saturation bounds of a signed DATA_W value, held at RES_W
  localparam logic signed [RES_W-1:0] SAT_HI = {{(RES_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [RES_W-1:0] SAT_LO = ~SAT_HI;

  // Arithmetic shift (floor), optional ReLU, then clamp to signed DATA_W
  function automatic logic [DATA_W-1:0] quantize(input logic [RES_W-1:0] x,
                                                 input logic [CMD_SHIFT_W-1:0] shift,
                                                 input logic relu);
    logic signed [RES_W-1:0] t;
    if (relu && x[RES_W-1]) t = '0;
    else                    t = $signed(x) >>> shift;
    if (t > SAT_HI)      return {1'b0, {(DATA_W-1){1'b1}}};
    else if (t < SAT_LO) return {1'b1, {(DATA_W-1){1'b0}}};
    else                 return t[DATA_W-1:0];
  endfunction

  // Quantize a whole 4-lane read word; lane-major, batch-minor packing
  function automatic logic [DDR_BEAT_W-1:0] quant_beat(input logic [3:0][BATCH*RES_W-1:0] d,
                                                      input logic [CMD_SHIFT_W-1:0] shift,
                                                      input logic relu);
    logic [DDR_BEAT_W-1:0] q;
    q = '0;
    for (int l = 0; l < 4; l++)
      for (int b = 0; b < BATCH; b++)
        q[(l*BATCH+b)*DATA_W +: DATA_W] = quantize(d[l][b*RES_W +: RES_W], shift, relu);
    return q;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO with occupancy count, active-low synchronous reset.
// Latency: a pushed word is visible at pop_data the cycle after the push.
// Backpressure: push is ignored when full and pop when empty; callers must respect count.
module wb_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH+1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == CNT_W'(0));
  assign full     = (count == CNT_W'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy tracking; simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: it is only read behind a nonzero count
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pe2ddr_writeback.sv
// Drains PE accumulation buffers group by group, quantizes them and writes one DDR burst per group.
// Latency: first ddr_valid 2 cycles after the address handshake; done 1 cycle after the final beat.
// Backpressure: ddr_ready stalls the skid FIFO; buffer reads throttle so FIFO plus in-flight never exceeds its depth.
module pe2ddr_writeback
  import pe2ddr_writeback_pkg::*;
#(
  parameter  int PE_NUM     = 32,
  parameter  int BUF_DEPTH  = 256,
  parameter  int DDR_W      = 256,
  parameter  int FIFO_DEPTH = 4,
  localparam int ADDR_W     = bw(BUF_DEPTH),
  localparam int GRP_W      = bw(PE_NUM/4)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [DDR_ADDR_W-1:0]           cmd_addr,
  input  logic [ADDR_W-1:0]               cmd_len,
  input  logic [GRP_W-1:0]                cmd_grp,
  input  logic [CMD_SHIFT_W-1:0]          cmd_shift,
  input  logic                            cmd_relu,
  output logic [GRP_W-1:0]                rd_sel,
  output logic [ADDR_W-1:0]               abuf_rd_addr,
  input  logic [3:0][BATCH*RES_W-1:0]     abuf_rd_data,
  output logic [DDR_ADDR_W-1:0]           ddr_addr,
  output logic [BURST_W-1:0]              ddr_size,
  output logic                            ddr_addr_valid,
  input  logic                            ddr_addr_ready,
  output logic [DDR_W-1:0]                ddr_data,
  output logic                            ddr_valid,
  input  logic                            ddr_ready,
  output logic                            done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  wb_state_e                state;
  logic [ADDR_W-1:0]        len_q;
  logic [GRP_W-1:0]         grp_q;
  logic [CMD_SHIFT_W-1:0]   shift_q;
  logic                     relu_q;
  logic [DDR_ADDR_W-1:0]    stride_q;
  logic                     rd_inflight;
  logic [CNT_W-1:0]         fifo_count;
  logic                     fifo_empty;
  logic [DDR_W-1:0]         fifo_din;
  logic [DDR_W-1:0]         fifo_dout;
  logic                     fifo_pop;
  logic                     rd_issue;
  logic                     flush_ok;

  // The read issued last cycle returns now and is pushed already quantized
  assign fifo_din  = quant_beat(abuf_rd_data, shift_q, relu_q);
  assign ddr_valid = !fifo_empty;
  assign fifo_pop  = ddr_valid && ddr_ready;
  assign ddr_data  = ddr_valid ? fifo_dout : '0;

  // Reserve a FIFO slot for every outstanding read so returning data always fits
  assign rd_issue = (state == WB_DATA) &&
                    ((int'(fifo_count) + int'(rd_inflight)) < FIFO_DEPTH);

  // FIFO drains this cycle: lets done land one cycle after the final beat
  assign flush_ok = !rd_inflight &&
                    ((fifo_count == CNT_W'(0)) || ((fifo_count == CNT_W'(1)) && fifo_pop));

  wb_fifo #(
    .WIDTH (DDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_inflight),
    .push_data (fifo_din),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Command sequencer: address phase, read phase per group, then flush and done pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= WB_IDLE;
      cmd_ready      <= 1'b1;
      rd_sel         <= '0;
      abuf_rd_addr   <= '0;
      ddr_addr       <= '0;
      ddr_size       <= '0;
      ddr_addr_valid <= 1'b0;
      done           <= 1'b0;
      rd_inflight    <= 1'b0;
      len_q          <= '0;
      grp_q          <= '0;
      shift_q        <= '0;
      relu_q         <= 1'b0;
      stride_q       <= '0;
    end else begin
      done        <= 1'b0;
      rd_inflight <= rd_issue;
      case (state)
        WB_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            len_q          <= cmd_len;
            grp_q          <= cmd_grp;
            shift_q        <= cmd_shift;
            relu_q         <= cmd_relu;
            stride_q       <= (DDR_ADDR_W'(cmd_len) + 1'b1) * DDR_ADDR_W'(DDR_W/8);
            cmd_ready      <= 1'b0;
            rd_sel         <= '0;
            ddr_addr       <= cmd_addr;
            ddr_size       <= BURST_W'(cmd_len);
            ddr_addr_valid <= 1'b1;
            state          <= WB_ADDR;
          end
        end
        WB_ADDR: begin
          if (ddr_addr_ready) begin
            ddr_addr_valid <= 1'b0;
            abuf_rd_addr   <= '0;
            state          <= WB_DATA;
          end
        end
        WB_DATA: begin
          if (rd_issue) begin
            if (abuf_rd_addr == len_q) begin
              if (rd_sel == grp_q) begin
                state <= WB_FLUSH;
              end else begin
                rd_sel         <= rd_sel + 1'b1;
                ddr_addr       <= ddr_addr + stride_q;
                ddr_addr_valid <= 1'b1;
                state          <= WB_ADDR;
              end
            end else begin
              abuf_rd_addr <= abuf_rd_addr + 1'b1;
            end
          end
        end
        WB_FLUSH: begin
          if (flush_ok) begin
            done  <= 1'b1;
            state <= WB_DONE;
          end
        end
        WB_DONE: begin
          cmd_ready <= 1'b1;
          state     <= WB_IDLE;
        end
        default: state <= WB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe2ddr_writeback.sv
// Scoreboard bench for pe2ddr_writeback: expectations queued at command issue, monitor checks beats.
module tb_pe2ddr_writeback;
  import pe2ddr_writeback_pkg::*;

  localparam int AW = 8;
  localparam int GW = 3;
  localparam int DW = 256;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        cmd_valid;
  logic                        cmd_ready;
  logic [DDR_ADDR_W-1:0]       cmd_addr;
  logic [AW-1:0]               cmd_len;
  logic [GW-1:0]               cmd_grp;
  logic [4:0]                  cmd_shift;
  logic                        cmd_relu;
  logic [GW-1:0]               rd_sel;
  logic [AW-1:0]               abuf_rd_addr;
  logic [3:0][BATCH*RES_W-1:0] abuf_rd_data;
  logic [DDR_ADDR_W-1:0]       ddr_addr;
  logic [BURST_W-1:0]          ddr_size;
  logic                        ddr_addr_valid;
  logic                        ddr_addr_ready;
  logic [DW-1:0]               ddr_data;
  logic                        ddr_valid;
  logic                        ddr_ready;
  logic                        done;

  always #5 clk = ~clk;

  pe2ddr_writeback dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_addr       (cmd_addr),
    .cmd_len        (cmd_len),
    .cmd_grp        (cmd_grp),
    .cmd_shift      (cmd_shift),
    .cmd_relu       (cmd_relu),
    .rd_sel         (rd_sel),
    .abuf_rd_addr   (abuf_rd_addr),
    .abuf_rd_data   (abuf_rd_data),
    .ddr_addr       (ddr_addr),
    .ddr_size       (ddr_size),
    .ddr_addr_valid (ddr_addr_valid),
    .ddr_addr_ready (ddr_addr_ready),
    .ddr_data       (ddr_data),
    .ddr_valid      (ddr_valid),
    .ddr_ready      (ddr_ready),
    .done           (done)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int beats_seen  = 0;
  int beats_pushed = 0;
  int last_beat_cyc = 0;

  logic [DW-1:0]         exp_q[$];
  logic [DDR_ADDR_W-1:0] exp_addr_q[$];
  logic [BURST_W-1:0]    exp_size_q[$];
  logic [GW-1:0]         exp_sel_q[$];
  int                    done_at_q[$];

  // Buffer content: pattern g*4096+w*16+e, or one constant in every element
  int               pat_mode = 0;
  logic [RES_W-1:0] const_x = '0;
  logic [15:0]      const_exp = '0;
  logic             rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [RES_W-1:0] elem(input int g, input int w, input int e);
    return (pat_mode != 0) ? const_x : RES_W'(g*4096 + w*16 + e);
  endfunction

  // PE array model: registered read, one cycle latency
  always @(posedge clk) begin
    for (int l = 0; l < 4; l++)
      for (int b = 0; b < 4; b++)
        abuf_rd_data[l][b*RES_W +: RES_W] <= elem(int'(rd_sel), int'(abuf_rd_addr), l*4+b);
  end

  // Ready drivers: all-ones or roughly 30% random
  initial begin
    ddr_ready = 1'b1;
    ddr_addr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ddr_ready      = rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
      ddr_addr_ready = rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  task automatic fail(input string name, input string msg);
    vectors++;
    miscompares++;
    $display("FAIL %s: %s", name, msg);
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_beat(input int g, input int w);
    logic [DW-1:0] r;
    for (int e = 0; e < 16; e++)
      r[e*16 +: 16] = (pat_mode != 0) ? const_exp : 16'(g*4096 + w*16 + e);
    return r;
  endfunction

  task automatic push_expect(input logic [31:0] base, input int len, input int grp);
    for (int g = 0; g <= grp; g++) begin
      exp_addr_q.push_back(base + 32'(g * (len + 1) * 32));
      exp_size_q.push_back(BURST_W'(len));
      exp_sel_q.push_back(GW'(g));
      for (int w = 0; w <= len; w++) begin
        exp_q.push_back(exp_beat(g, w));
        beats_pushed++;
      end
    end
    done_at_q.push_back(beats_pushed);
  endtask

  // Monitor: handshake checks, payload stability, done accounting
  logic          prev_done = 1'b0;
  logic          hold_d = 1'b0;
  logic          hold_a = 1'b0;
  logic [DW-1:0] hold_dat;
  logic [31:0]   hold_adr;

  always @(negedge clk) begin
    if (!rst) begin
      prev_done = 1'b0;
      hold_d = 1'b0;
      hold_a = 1'b0;
    end else begin
      if (hold_d) begin
        check("ddr_valid_hold", DW'(ddr_valid), DW'(1));
        check("ddr_data_hold", ddr_data, hold_dat);
      end
      if (hold_a) begin
        check("addr_valid_hold", DW'(ddr_addr_valid), DW'(1));
        check("addr_hold", DW'(ddr_addr), DW'(hold_adr));
      end
      hold_d   = ddr_valid && !ddr_ready;
      hold_dat = ddr_data;
      hold_a   = ddr_addr_valid && !ddr_addr_ready;
      hold_adr = ddr_addr;
      if (ddr_addr_valid && ddr_addr_ready) begin
        if (exp_addr_q.size() == 0) fail("unexpected_addr", $sformatf("addr %h", ddr_addr));
        else begin
          check("ddr_addr", DW'(ddr_addr), DW'(exp_addr_q.pop_front()));
          check("ddr_size", DW'(ddr_size), DW'(exp_size_q.pop_front()));
          check("rd_sel", DW'(rd_sel), DW'(exp_sel_q.pop_front()));
        end
      end
      if (ddr_valid && ddr_ready) begin
        if (exp_q.size() == 0) fail("unexpected_beat", $sformatf("data %h", ddr_data));
        else check("beat", ddr_data, exp_q.pop_front());
        beats_seen++;
        last_beat_cyc = cyc;
      end
      if (done) begin
        if (prev_done) fail("done_width", "done high two cycles");
        if (done_at_q.size() == 0) fail("unexpected_done", "no command outstanding");
        else begin
          check("done_after_beats", DW'(beats_seen), DW'(done_at_q.pop_front()));
          check("done_latency", DW'(cyc - last_beat_cyc), DW'(1));
        end
      end
      prev_done = done;
    end
  end

  task automatic send_cmd(input logic [31:0] a, input int len, input int grp,
                          input logic [4:0] sh, input logic rl);
    bit hs = 1'b0;
    int n = 0;
    push_expect(a, len, grp);
    @(posedge clk);
    #1;
    cmd_addr = a; cmd_len = AW'(len); cmd_grp = GW'(grp); cmd_shift = sh; cmd_relu = rl;
    cmd_valid = 1'b1;
    while (!hs && n < 2000) begin
      @(negedge clk);
      hs = cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end
    cmd_valid = 1'b0;
    if (!hs) fail("cmd_accept_timeout", "cmd_ready never seen");
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((done_at_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) fail("drain_timeout", $sformatf("%0d beats left", exp_q.size()));
    @(negedge clk);
    check("cmd_ready_idle", DW'(cmd_ready), DW'(1));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cmd_ready"}, DW'(cmd_ready), DW'(1));
    check({tag, "_rd_sel"}, DW'(rd_sel), '0);
    check({tag, "_abuf_rd_addr"}, DW'(abuf_rd_addr), '0);
    check({tag, "_ddr_addr"}, DW'(ddr_addr), '0);
    check({tag, "_ddr_size"}, DW'(ddr_size), '0);
    check({tag, "_ddr_data"}, ddr_data, '0);
    check({tag, "_ddr_addr_valid"}, DW'(ddr_addr_valid), '0);
    check({tag, "_ddr_valid"}, DW'(ddr_valid), '0);
    check({tag, "_done"}, DW'(done), '0);
  endtask

  // Quantization vectors: RES_W input, shift, relu, hand-computed DATA_W result
  logic [31:0] qx  [11] = '{32'h0001_2345, 32'h0010_0000, 32'hFFF0_0000, 32'hFFFF_FFFB,
                            32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'h0000_7FFF, 32'hFFFF_8000,
                            32'h0000_8000, 32'h0001_2345, 32'h8000_0000};
  logic [4:0]  qsh [11] = '{5'd4, 5'd0, 5'd4, 5'd0, 5'd0, 5'd1, 5'd0, 5'd0, 5'd0, 5'd4, 5'd31};
  logic        qrl [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [15:0] qex [11] = '{16'h1234, 16'h7FFF, 16'h8000, 16'h0000, 16'hFFFB, 16'hFFFD,
                            16'h7FFF, 16'h8000, 16'h7FFF, 16'h1234, 16'hFFFF};

  initial begin
    int start;
    int n;
    bit accepted;
    logic prev_cycle_done;
    rst = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr = '0; cmd_len = '0; cmd_grp = '0; cmd_shift = '0; cmd_relu = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("init");
    @(posedge clk);
    #1 rst = 1'b1;

    // Single group, four words
    pat_mode = 0;
    send_cmd(32'h1000_0000, 3, 0, 5'd0, 1'b0);
    wait_drain(200);

    // Quantization corners, one single-word burst each
    pat_mode = 1;
    for (int i = 0; i < 11; i++) begin
      const_x = qx[i];
      const_exp = qex[i];
      send_cmd(32'h2000_0000 + 32'(i*32), 0, 0, qsh[i], qrl[i]);
      wait_drain(100);
    end

    // Eight groups of 256 words at full rate
    pat_mode = 0;
    start = beats_seen;
    send_cmd(32'h4000_0000, 255, 7, 5'd0, 1'b0);
    wait_drain(5000);
    check("multi_beats", DW'(beats_seen - start), DW'(2048));

    // Random backpressure on both channels, address wraps past 2^32
    rand_ready = 1'b1;
    send_cmd(32'hFFFF_F000, 63, 3, 5'd0, 1'b0);
    wait_drain(20000);
    rand_ready = 1'b0;

    // Reset after 10 beats of 64: abort with no done
    start = beats_seen;
    send_cmd(32'h5000_0000, 63, 0, 5'd0, 1'b0);
    n = 0;
    while (beats_seen - start < 10 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) fail("reset_wait_timeout", "beat 10 never reached");
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset("midrst");
    exp_q.delete(); exp_addr_q.delete(); exp_size_q.delete(); exp_sel_q.delete(); done_at_q.delete();
    beats_pushed = beats_seen;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (20) @(posedge clk);

    // A fresh command completes after the abort
    send_cmd(32'h6000_0000, 7, 1, 5'd0, 1'b0);
    wait_drain(300);

    // Second command held valid while the first is busy
    send_cmd(32'h7000_0000, 15, 0, 5'd0, 1'b0);
    push_expect(32'h7100_0000, 3, 1);
    cmd_addr = 32'h7100_0000; cmd_len = AW'(3); cmd_grp = GW'(1); cmd_shift = '0; cmd_relu = 1'b0;
    cmd_valid = 1'b1;
    accepted = 1'b0;
    prev_cycle_done = 1'b0;
    n = 0;
    while (!accepted && n < 500) begin
      @(negedge clk);
      if (cmd_ready) begin
        check("busy_accept_after_done", DW'(prev_cycle_done), DW'(1));
        accepted = 1'b1;
      end
      prev_cycle_done = done;
      @(posedge clk);
      #1;
      n++;
    end
    cmd_valid = 1'b0;
    if (!accepted) fail("busy_accept_timeout", "second command never accepted");
    wait_drain(300);

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
